// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out change from the penny, farthing and half-farthing hoppers.
//   A change amount (in half-farthings) is latched in IDLE. The block then
//   requests one coin at a time, choosing the largest coin that still fits
//   and whose hopper is not empty. Each coin uses a valid/ack handshake.
//   The block ends with a one-cycle done pulse when exact change has been
//   paid, or a one-cycle fail pulse when no remaining coin fits. After a
//   fail, rem_amt holds the shortfall.
//
//   Optional build macro DISP_TIMEOUT_EN: abandon a coin request that has
//   had no coin_ack after TIMEOUT DISPENSE cycles, and report fail.
//
// Ports
//   CLK        in   system clock, rising edge
//   RES        in   asynchronous active-low reset
//   req_valid  in   change request present (sampled in IDLE only)
//   req_amt    in   change amount, half-farthings (Pen=8, Fa=2, HFa=1)
//   req_ready  out  idle, can accept a request
//   pen_empty  in   penny hopper empty
//   fa_empty   in   farthing hopper empty
//   hfa_empty  in   half-farthing hopper empty
//   coin_valid out  coin dispense request
//   coin_sel   out  one-hot {Pen,Fa,HFa}, zero when coin_valid=0
//   coin_ack   in   hopper released the selected coin
//   rem_amt    out  amount still owed
//   busy       out  transaction in progress
//   done       out  one-cycle pulse, exact change paid
//   fail       out  one-cycle pulse, change cannot be completed
module change_dispenser #(
    parameter int AMT_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amt,
    output logic             req_ready,
    input  logic             pen_empty,
    input  logic             fa_empty,
    input  logic             hfa_empty,
    output logic             coin_valid,
    output logic [2:0]       coin_sel,
    input  logic             coin_ack,
    output logic [AMT_W-1:0] rem_amt,
    output logic             busy,
    output logic             done,
    output logic             fail
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        DISPENSE,
        DONE,
        FAIL
    } state_t;

    localparam logic [2:0] SEL_PEN = 3'b100;
    localparam logic [2:0] SEL_FA  = 3'b010;
    localparam logic [2:0] SEL_HFA = 3'b001;

    localparam logic [AMT_W-1:0] VAL_PEN = AMT_W'(8);
    localparam logic [AMT_W-1:0] VAL_FA  = AMT_W'(2);
    localparam logic [AMT_W-1:0] VAL_HFA = AMT_W'(1);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [2:0]       sel_q, sel_d;
    logic [AMT_W-1:0] coin_value;

`ifdef DISP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
        end
    end

`ifdef DISP_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Value of the coin currently being requested.
    always_comb begin
        coin_value = '0;
        unique case (sel_q)
            SEL_PEN: coin_value = VAL_PEN;
            SEL_FA:  coin_value = VAL_FA;
            SEL_HFA: coin_value = VAL_HFA;
            default: coin_value = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
`ifdef DISP_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rem_d   = req_amt;
                    state_d = SELECT;
                end
            end
            SELECT: begin
`ifdef DISP_TIMEOUT_EN
                cnt_d = '0;
`endif
                // Greedy choice. A coin is picked only when its value fits,
                // so the later subtraction never underflows.
                if (rem_q == '0) begin
                    state_d = DONE;
                end else if (!pen_empty && rem_q >= VAL_PEN) begin
                    sel_d   = SEL_PEN;
                    state_d = DISPENSE;
                end else if (!fa_empty && rem_q >= VAL_FA) begin
                    sel_d   = SEL_FA;
                    state_d = DISPENSE;
                end else if (!hfa_empty && rem_q >= VAL_HFA) begin
                    sel_d   = SEL_HFA;
                    state_d = DISPENSE;
                end else begin
                    state_d = FAIL;
                end
            end
            DISPENSE: begin
                if (coin_ack) begin
                    rem_d   = rem_q - coin_value;
                    state_d = SELECT;
                end
`ifdef DISP_TIMEOUT_EN
                // The count includes the current cycle, so coin_valid stays
                // high for exactly TIMEOUT cycles before giving up.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = FAIL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign coin_valid = (state_q == DISPENSE);
    assign coin_sel   = coin_valid ? sel_q : '0;
    assign rem_amt    = rem_q;
    assign done       = (state_q == DONE);
    assign fail       = (state_q == FAIL);

endmodule
